// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add mult between two requesters.
// Optional WAIT timeout abort is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int WIDTH   = 3,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [2*WIDTH-1:0]   res,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  output logic                 mult_init,
  input  logic [2*WIDTH-1:0]   mult_result,
  input  logic                 mult_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  logic   last;
  logic   sel;
  logic   grant1;
  logic   tmo;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant1 = req1 && (!req0 || !last);
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  always_comb begin
    tmo = (cnt == CNT_W'(TIMEOUT - 1));
  end
`else
  always_comb begin
    tmo = 1'b0;
  end
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      mult_init <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res       <= '0;
      busy      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      err       <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      mult_init <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state     <= S_LAUNCH;
            busy      <= 1'b1;
            mult_init <= 1'b1;
            last      <= grant1;
            sel       <= grant1;
            mult_a    <= grant1 ? a1 : a0;
            mult_b    <= grant1 ? b1 : b0;
          end
        end
        S_LAUNCH: state <= S_GUARD;
        // mult has no reset, so a stale done may linger until init has taken effect.
        S_GUARD: begin
          state <= S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (mult_done) begin
            state <= S_RESP;
            res   <= mult_result;
            ack0  <= !sel;
            ack1  <= sel;
`ifdef MULT_ARB_TIMEOUT_EN
            err   <= 1'b0;
`endif
          end else if (tmo) begin
            state <= S_RESP;
            res   <= '0;
            ack0  <= !sel;
            ack1  <= sel;
`ifdef MULT_ARB_TIMEOUT_EN
            err   <= 1'b1;
`endif
          end else begin
`ifdef MULT_ARB_TIMEOUT_EN
            cnt   <= cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural shift-add multiplier model.
// Honours MULT_ARB_TIMEOUT_EN to pick the timeout or the hang scenario.
module tb_mult_arbiter;

  localparam int WIDTH = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0, req1;
  logic [WIDTH-1:0]   a0, b0, a1, b1;
  logic               ack0, ack1;
  logic [2*WIDTH-1:0] res;
  logic               err, busy;
  logic [WIDTH-1:0]   mult_a, mult_b;
  logic               mult_init;
  logic [2*WIDTH-1:0] mult_result;
  logic               mult_done;

  mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .res(res), .err(err), .busy(busy),
    .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init),
    .mult_result(mult_result), .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int res; int err; } exp_t;
  typedef struct { int a; int b; } op_t;

  exp_t exp_q[$];
  op_t  launch_q[$];
  op_t  rq0[$];
  op_t  rq1[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Multiplier model: no reset, three-cycle latency, done held until next init.
  bit             stub = 1'b0;
  int             mcnt = 0;
  logic [WIDTH-1:0] ma, mb;

  always @(posedge clk) begin
    if (mult_init) begin
      ma        <= mult_a;
      mb        <= mult_b;
      mcnt      <= 3;
      mult_done <= 1'b0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !stub) begin
        mult_result <= {3'b000, ma} * {3'b000, mb};
        mult_done   <= 1'b1;
      end
    end
  end

  // Monitor: launches and acknowledges are checked against the scoreboard queues.
  always @(negedge clk) begin
    if (mult_init) begin
      chk("init_ack_overlap", int'(ack0 | ack1), 0);
      if (launch_q.size() == 0) begin
        chk("init_unexpected", int'(mult_init), 0);
      end else begin
        op_t o;
        o = launch_q.pop_front();
        chk("init_a", int'(mult_a), o.a);
        chk("init_b", int'(mult_b), o.b);
      end
    end
    if (ack0 || ack1) begin
      chk("ack_both", int'(ack0 & ack1), 0);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", int'({ack1, ack0}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_id", int'({ack1, ack0}), (e.id == 0) ? 1 : 2);
        chk("res", int'(res), e.res);
        chk("err", int'(err), e.err);
      end
    end
  end

  function automatic int all_outs();
    return int'({ack0, ack1, err, busy, mult_init, res, mult_a, mult_b});
  endfunction

  task automatic run_ops(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (ack0) begin
        if (rq0.size() != 0) begin
          op_t o;
          o = rq0.pop_front();
          a0 = WIDTH'(o.a);
          b0 = WIDTH'(o.b);
        end else begin
          req0 = 1'b0;
        end
      end
      if (ack1) begin
        if (rq1.size() != 0) begin
          op_t o;
          o = rq1.pop_front();
          a1 = WIDTH'(o.a);
          b1 = WIDTH'(o.b);
        end else begin
          req1 = 1'b0;
        end
      end
    end
    chk("ops_complete", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    int nack;

    // Reset held with both requests active: nothing may move.
    rst = 1'b1;
    req0 = 1'b1; a0 = 3'd7; b0 = 3'd7;
    req1 = 1'b1; a1 = 3'd2; b1 = 3'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", all_outs(), 0);
    end

    // Tie after reset, with both requesters re-arming once on their ack.
    launch_q.push_back('{7, 7});
    launch_q.push_back('{2, 3});
    launch_q.push_back('{4, 5});
    launch_q.push_back('{3, 3});
    exp_q.push_back('{0, 49, 0});
    exp_q.push_back('{1, 6, 0});
    exp_q.push_back('{0, 20, 0});
    exp_q.push_back('{1, 9, 0});
    rq0.push_back('{4, 5});
    rq1.push_back('{3, 3});
    rst = 1'b0;
    run_ops(200);

    // Single request with latency checks.
    @(negedge clk);
    a0 = 3'd3; b0 = 3'd5; req0 = 1'b1;
    launch_q.push_back('{3, 5});
    exp_q.push_back('{0, 15, 0});
    @(negedge clk);
    chk("init_latency", int'(mult_init), 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      #1;
      if (i < 5) chk("ack_early", int'(ack0), 0);
      else       chk("ack_latency", int'(ack0), 1);
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("idle_after_resp", int'(busy), 0);
    run_ops(20);

    // req1 dropped during WAIT: operation must still complete, no relaunch.
    @(negedge clk);
    a1 = 3'd5; b1 = 3'd6; req1 = 1'b1;
    launch_q.push_back('{5, 6});
    exp_q.push_back('{1, 30, 0});
    repeat (3) @(negedge clk);
    req1 = 1'b0;
    run_ops(50);
    repeat (4) begin
      @(negedge clk);
      chk("no_relaunch", int'({busy, mult_init}), 0);
    end

    // Reset during WAIT aborts without an ack.
    @(negedge clk);
    a0 = 3'd2; b0 = 3'd3; req0 = 1'b1;
    launch_q.push_back('{2, 3});
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("async_rst_outs", all_outs(), 0);
    @(negedge clk);
    chk("rst_hold_outs", all_outs(), 0);
    rst = 1'b0;
    nack = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack0 || ack1) nack++;
    end
    chk("abort_no_ack", nack, 0);
    a0 = 3'd1; b0 = 3'd6; req0 = 1'b1;
    launch_q.push_back('{1, 6});
    exp_q.push_back('{0, 6, 0});
    run_ops(50);

`ifdef MULT_ARB_TIMEOUT_EN
    // Multiplier never completes: abort after 31 WAIT cycles.
    stub = 1'b1;
    @(negedge clk);
    a0 = 3'd2; b0 = 3'd2; req0 = 1'b1;
    launch_q.push_back('{2, 2});
    exp_q.push_back('{0, 0, 1});
    @(negedge clk);
    chk("tmo_init", int'(mult_init), 1);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      #1;
      if (i < 33) chk("tmo_ack_early", int'(ack0), 0);
      else        chk("tmo_ack", int'(ack0), 1);
    end
    req0 = 1'b0;
    run_ops(10);
    stub = 1'b0;
`else
    // Multiplier never completes: the arbiter stays busy indefinitely.
    stub = 1'b1;
    @(negedge clk);
    a0 = 3'd2; b0 = 3'd2; req0 = 1'b1;
    launch_q.push_back('{2, 2});
    nbusy = 0;
    nack = 0;
    @(negedge clk);
    repeat (200) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (ack0 || ack1) nack++;
    end
    chk("hang_busy_cycles", nbusy, 200);
    chk("hang_no_ack", nack, 0);
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("hang_rst_outs", all_outs(), 0);
    rst = 1'b0;
    stub = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("launch_queue_drained", launch_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
